int_vect_ctrl: RTL and testbench
================================

// Module: int_vect_ctrl
// PURPOSE
//  Interrupt controller consuming the level interrupt/ack pairs of peripheral timers (rtc, etc).
//  Selects one pending source, raises a vectored request to the core.
//  On core acknowledge, returns a one-cycle ack pulse to the selected source.
//  Waits for that source to drop its request before arbitrating again.
// PARAMETERS
//  NUM_INT     8   number of interrupt sources, 2..32
//  VECT_W      3   width of vector index, must satisfy 2**VECT_W >= NUM_INT
//  CLR_TIMEOUT 15  max cycles in CLEAR waiting for source deassert, 1..255
// PORTS
//  clk_i       in  1        single clock, rising edge
//  rst_i       in  1        asynchronous, active-low reset
//  int_i       in  NUM_INT  level requests from sources
//  en_i        in  NUM_INT  per-source enable mask, 1 = enabled
//  gie_i       in  1        global interrupt enable from core
//  int_ack_o   out NUM_INT  one-hot ack pulse to the serviced source
//  cpu_int_o   out 1        interrupt request to core
//  cpu_vect_o  out VECT_W   index of the requested source, stable while cpu_int_o=1
//  cpu_ack_i   in  1        core accepted vector, sampled only while cpu_int_o=1
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, cpu_int_o=0, cpu_vect_o=0, int_ack_o=0,
//   timeout counter=0, RR pointer=0.
//  pend = int_i & en_i.
//  All outputs are registered.
//  FSM states: IDLE, REQ, ACK, CLEAR.
//  IDLE
//   - if gie_i & |pend: latch selected index into cpu_vect_o, go REQ.
//   - cpu_int_o=1 from the following edge; latency 1 cycle from pend seen.
//  REQ
//   - cpu_int_o=1; cpu_vect_o frozen; new or higher-priority pends are ignored.
//   - cpu_ack_i=1: go ACK. Ack wins over a withdrawal in the same cycle.
//   - else if ~gie_i | ~int_i[v] | ~en_i[v]: withdraw.
//     cpu_int_o=0 next cycle, go IDLE, no ack issued.
//  ACK (exactly 1 cycle)
//   - int_ack_o[v]=1, all other bits 0; cpu_int_o=0.
//   - Clear timeout counter, go CLEAR.
//  CLEAR
//   - int_i[v]=0: go IDLE.
//   - else counter++; on counter==CLR_TIMEOUT go IDLE regardless.
//     A source stuck high is re-arbitrated, no deadlock.
//  Priority without macro: fixed, lowest index wins.
//  cpu_int_o never rises again earlier than 2 cycles after its fall.
//  Only one source is ever in flight; int_ack_o is always zero or one-hot.
//  Assertion of rst_i in any state aborts the cycle: all outputs low asynchronously.
//  No ack is issued for the aborted request.
// CONFIGURATION
//  INT_VECT_CTRL_ROUND_ROBIN_EN defined:
//   - Rotating priority: the search starts at (last acked index + 1) mod NUM_INT.
//   - Pointer updates only in ACK; a withdrawal does not move it.
//  Undefined: fixed lowest-index priority, no pointer register.
// TESTING
//  1. NUM_INT=8, en=FF, gie=1, int_i[3] high.
//     -> cpu_int_o high next cycle, vect=3.
//     cpu_ack 1 cycle -> int_ack_o=08 for exactly 1 cycle.
//     Source drops -> IDLE.
//  2. int_i=0x24 together, fixed priority.
//     -> vect=2 serviced first, then vect=5 after int_i[2] clears.
//  3. In REQ, drop int_i[v] with cpu_ack_i=0.
//     -> cpu_int_o low next cycle, int_ack_o stays 0.
//     Repeat with cpu_ack_i=1 same cycle -> ack still issued.
//  4. Source ignores ack, int_i[1] stuck high, CLR_TIMEOUT=15.
//     -> IDLE after 15 cycles in CLEAR, request re-raised with vect=1.
//  5. With INT_VECT_CTRL_ROUND_ROBIN_EN, int_i=0x81 held with auto-clear.
//     -> vectors 0,7,0,7...
//     Without macro: 0,0,...
//  6. Assert rst_i while in ACK -> int_ack_o, cpu_int_o low without a clock edge.
//     Release -> IDLE.

Source files
------------

// File: rtl/int_vect_ctrl.sv
// Vectored interrupt controller: arbitrates level requests, presents one vector to the core,
// pulses an ack back to the serviced source. Optional macro INT_VECT_CTRL_ROUND_ROBIN_EN.
module int_vect_ctrl #(
    parameter int NUM_INT     = 8,
    parameter int VECT_W      = 3,
    parameter int CLR_TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_INT-1:0] int_i,
    input  logic [NUM_INT-1:0] en_i,
    input  logic               gie_i,
    output logic [NUM_INT-1:0] int_ack_o,
    output logic               cpu_int_o,
    output logic [VECT_W-1:0]  cpu_vect_o,
    input  logic               cpu_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ACK   = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    localparam logic [7:0]         CLR_TO_C = 8'(CLR_TIMEOUT);
    localparam logic [NUM_INT-1:0] ONE_C    = {{(NUM_INT-1){1'b0}}, 1'b1};
    localparam logic [VECT_W:0]    NUM_C    = (VECT_W+1)'(NUM_INT);

    state_t               state_q, state_d;
    logic [VECT_W-1:0]    vect_q, vect_d;
    logic                 cpu_int_q, cpu_int_d;
    logic [NUM_INT-1:0]   int_ack_q, int_ack_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 hold_q, hold_d;
    logic [NUM_INT-1:0]   pend_s;
    logic [VECT_W-1:0]    sel_s;
    logic                 withdraw_s;

    function automatic logic [VECT_W-1:0] pick_fixed(input logic [NUM_INT-1:0] req);
        logic [VECT_W-1:0] idx;
        idx = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = VECT_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

`ifdef INT_VECT_CTRL_ROUND_ROBIN_EN
    logic [VECT_W-1:0] ptr_q, ptr_d;

    // Rotate so the start index lands on bit 0, find lowest, then rotate the index back.
    function automatic logic [VECT_W-1:0] pick_rr(input logic [NUM_INT-1:0] req,
                                                  input logic [VECT_W-1:0] start);
        logic [NUM_INT-1:0] rot;
        logic [VECT_W-1:0]  off;
        logic [VECT_W:0]    sum;
        logic [VECT_W-1:0]  idx;
        rot = NUM_INT'({req, req} >> start);
        off = pick_fixed(rot);
        sum = {1'b0, off} + {1'b0, start};
        if (sum >= NUM_C) begin
            idx = VECT_W'(sum - NUM_C);
        end else begin
            idx = sum[VECT_W-1:0];
        end
        return idx;
    endfunction

    function automatic logic [VECT_W-1:0] next_idx(input logic [VECT_W-1:0] v);
        logic [VECT_W:0]   sum;
        logic [VECT_W-1:0] idx;
        sum = {1'b0, v} + {{VECT_W{1'b0}}, 1'b1};
        if (sum >= NUM_C) begin
            idx = '0;
        end else begin
            idx = sum[VECT_W-1:0];
        end
        return idx;
    endfunction

    assign sel_s = pick_rr(pend_s, ptr_q);
`else
    assign sel_s = pick_fixed(pend_s);
`endif

    assign pend_s     = int_i & en_i;
    assign withdraw_s = ~gie_i | ~int_i[vect_q] | ~en_i[vect_q];

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            vect_q    <= '0;
            cpu_int_q <= 1'b0;
            int_ack_q <= '0;
            cnt_q     <= 8'd0;
            hold_q    <= 1'b0;
`ifdef INT_VECT_CTRL_ROUND_ROBIN_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            vect_q    <= vect_d;
            cpu_int_q <= cpu_int_d;
            int_ack_q <= int_ack_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
`ifdef INT_VECT_CTRL_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    // Next-state logic; hold_q blocks one IDLE cycle after a withdrawal so the
    // request line stays low for at least two cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
`ifdef INT_VECT_CTRL_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                hold_d = 1'b0;
                if (gie_i && (|pend_s) && !hold_q) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (cpu_ack_i) begin
                    state_d = S_ACK;
                end else if (withdraw_s) begin
                    state_d = S_IDLE;
                    hold_d  = 1'b1;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_ACK: begin
                cnt_d   = 8'd0;
                state_d = S_CLEAR;
`ifdef INT_VECT_CTRL_ROUND_ROBIN_EN
                ptr_d   = next_idx(vect_q);
`endif
            end
            S_CLEAR: begin
                if (!int_i[vect_q]) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == CLR_TO_C) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next values derived from the upcoming state.
    always_comb begin
        cpu_int_d = (state_d == S_REQ);
        if (state_d == S_ACK) begin
            int_ack_d = ONE_C << vect_q;
        end else begin
            int_ack_d = '0;
        end
        if ((state_q == S_IDLE) && (state_d == S_REQ)) begin
            vect_d = sel_s;
        end else begin
            vect_d = vect_q;
        end
    end

    assign int_ack_o  = int_ack_q;
    assign cpu_int_o  = cpu_int_q;
    assign cpu_vect_o = vect_q;

endmodule

// File: tb/tb_int_vect_ctrl.sv
// Self-checking bench for int_vect_ctrl: directed table, hand sequences and
// randomized traffic against a transaction-level reference model.
module tb_int_vect_ctrl;

    localparam int N = 8;
    localparam int T = 15;

    logic         clk_r = 1'b0;
    logic         rst_r = 1'b0;
    logic [N-1:0] int_r = '0;
    logic [N-1:0] en_r  = '0;
    logic         gie_r = 1'b0;
    logic         ack_r = 1'b0;
    logic [N-1:0] int_ack_s;
    logic         cpu_int_s;
    logic [2:0]   cpu_vect_s;

    int errors = 0;
    int checks = 0;

    int_vect_ctrl #(.NUM_INT(N), .VECT_W(3), .CLR_TIMEOUT(T)) dut (
        .clk_i     (clk_r),
        .rst_i     (rst_r),
        .int_i     (int_r),
        .en_i      (en_r),
        .gie_i     (gie_r),
        .int_ack_o (int_ack_s),
        .cpu_int_o (cpu_int_s),
        .cpu_vect_o(cpu_vect_s),
        .cpu_ack_i (ack_r)
    );

    always #5 clk_r = ~clk_r;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    // Reference model: phases of one in-flight transaction.
    bit       m_req, m_clear;
    int       m_vect, m_cnt, m_age, m_ptr, m_ackidx;

    task automatic model_reset();
        m_req = 0; m_clear = 0; m_vect = 0; m_cnt = 0;
        m_age = 100; m_ptr = 0; m_ackidx = -1;
    endtask

    function automatic int pick(input logic [N-1:0] p, input int start);
        for (int k = 0; k < N; k++) begin
`ifdef INT_VECT_CTRL_ROUND_ROBIN_EN
            if (p[(start + k) % N]) return (start + k) % N;
`else
            if (p[k]) return k;
`endif
        end
        return 0;
    endfunction

    task automatic model_advance();
        logic [N-1:0] p;
        bit n_req, n_clear;
        int n_vect, n_cnt, n_age, n_ptr, n_ackidx;
        p = int_r & en_r;
        n_req = m_req; n_clear = m_clear; n_vect = m_vect; n_cnt = m_cnt;
        n_ptr = m_ptr; n_ackidx = -1;
        n_age = (m_age < 100) ? m_age + 1 : 100;
        if (m_req) begin
            if (ack_r) begin
                n_req = 0; n_ackidx = m_vect; n_age = 0;
            end else if (!gie_r || !int_r[m_vect] || !en_r[m_vect]) begin
                n_req = 0; n_age = 0;
            end
        end else if (m_ackidx >= 0) begin
            n_clear = 1; n_cnt = 0; n_ptr = (m_ackidx + 1) % N;
        end else if (m_clear) begin
            if (!int_r[m_vect]) n_clear = 0;
            else begin
                n_cnt = m_cnt + 1;
                if (n_cnt == T) n_clear = 0;
            end
        end else if (gie_r && (|p) && m_age >= 1) begin
            n_req = 1; n_vect = pick(p, m_ptr);
        end
        m_req = n_req; m_clear = n_clear; m_vect = n_vect; m_cnt = n_cnt;
        m_age = n_age; m_ptr = n_ptr; m_ackidx = n_ackidx;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_ack;
        model_advance();
        @(posedge clk_r);
        #1;
        exp_ack = (m_ackidx >= 0) ? (8'h01 << m_ackidx) : 8'h00;
        check("cpu_int", {31'd0, cpu_int_s}, {31'd0, m_req});
        check("cpu_vect", {29'd0, cpu_vect_s}, m_vect);
        check("int_ack", {24'd0, int_ack_s}, {24'd0, exp_ack});
        check("ack_onehot0", {31'd0, $onehot0(int_ack_s)}, 32'd1);
    endtask

    task automatic do_reset();
        rst_r = 1'b0; int_r = '0; ack_r = 1'b0; gie_r = 1'b1; en_r = 8'hFF;
        #2;
        check("rst_cpu_int", {31'd0, cpu_int_s}, 32'd0);
        check("rst_vect", {29'd0, cpu_vect_s}, 32'd0);
        check("rst_int_ack", {24'd0, int_ack_s}, 32'd0);
        model_reset();
        @(negedge clk_r);
        rst_r = 1'b1;
    endtask

    typedef struct {
        logic [7:0] in_int;
        logic       gie;
        logic       ack;
        logic       exp_int;
        logic [2:0] exp_vect;
        logic [7:0] exp_ack;
    } vec_t;

    vec_t tbl[23];
    int   v;
    int   exp_v;
    bit   got;

    initial begin
        tbl[0]  = '{8'h08, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00};
        tbl[1]  = '{8'h08, 1'b1, 1'b1, 1'b0, 3'd3, 8'h08};
        tbl[2]  = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00};
        tbl[3]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00};
        tbl[4]  = '{8'h24, 1'b1, 1'b0, 1'b1, 3'd2, 8'h00};
        tbl[5]  = '{8'h24, 1'b1, 1'b1, 1'b0, 3'd2, 8'h04};
        tbl[6]  = '{8'h20, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00};
        tbl[7]  = '{8'h20, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00};
        tbl[8]  = '{8'h20, 1'b1, 1'b0, 1'b1, 3'd5, 8'h00};
        tbl[9]  = '{8'h20, 1'b1, 1'b1, 1'b0, 3'd5, 8'h20};
        tbl[10] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00};
        tbl[11] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00};
        tbl[12] = '{8'h02, 1'b1, 1'b0, 1'b1, 3'd1, 8'h00};
        tbl[13] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00};
        tbl[14] = '{8'h02, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00};
        tbl[15] = '{8'h02, 1'b1, 1'b0, 1'b1, 3'd1, 8'h00};
        tbl[16] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 8'h02};
        tbl[17] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00};
        tbl[18] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00};
        tbl[19] = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00};
        tbl[20] = '{8'h01, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00};
        tbl[21] = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
        tbl[22] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00};

        model_reset();
        #12;
        do_reset();

`ifndef INT_VECT_CTRL_ROUND_ROBIN_EN
        // Directed table: single source, two simultaneous sources, withdrawal, gie gating.
        for (int i = 0; i < 23; i++) begin
            int_r = tbl[i].in_int; gie_r = tbl[i].gie; ack_r = tbl[i].ack; en_r = 8'hFF;
            step();
            check($sformatf("tbl%0d_int", i), {31'd0, cpu_int_s}, {31'd0, tbl[i].exp_int});
            check($sformatf("tbl%0d_vect", i), {29'd0, cpu_vect_s}, {29'd0, tbl[i].exp_vect});
            check($sformatf("tbl%0d_ack", i), {24'd0, int_ack_s}, {24'd0, tbl[i].exp_ack});
        end
`endif

        // Withdrawal and ack in the same cycle: ack wins.
        do_reset();
        int_r = 8'h10; step();
        int_r = 8'h00; ack_r = 1'b1; step();
        check("t3_ack_wins", {24'd0, int_ack_s}, 32'h10);
        ack_r = 1'b0; step(); step();

        // Stuck source: CLEAR gives up after exactly T cycles.
        do_reset();
        int_r = 8'h02; step();
        ack_r = 1'b1; step();
        ack_r = 1'b0; step();
        for (int k = 1; k <= T; k++) begin
            step();
            check($sformatf("t4_wait%0d", k), {31'd0, cpu_int_s}, 32'd0);
        end
        step();
        check("t4_rearb_int", {31'd0, cpu_int_s}, 32'd1);
        check("t4_rearb_vect", {29'd0, cpu_vect_s}, 32'd1);
        int_r = 8'h00; step(); step(); step();

        // Two sources held, each drops briefly after its ack.
        do_reset();
        int_r = 8'h81;
        for (int s = 0; s < 4; s++) begin
            got = 0;
            for (int k = 0; k < 10; k++) begin
                if (cpu_int_s) begin
                    got = 1;
                    break;
                end
                step();
            end
            check($sformatf("t5_req%0d", s), {31'd0, got}, 32'd1);
`ifdef INT_VECT_CTRL_ROUND_ROBIN_EN
            exp_v = (s % 2 == 1) ? 7 : 0;
`else
            exp_v = 0;
`endif
            check($sformatf("t5_vect%0d", s), {29'd0, cpu_vect_s}, exp_v);
            v = int'(cpu_vect_s);
            ack_r = 1'b1; step();
            ack_r = 1'b0; int_r = 8'h81 & ~(8'h01 << v); step(); step();
            int_r = 8'h81;
        end

        // Asynchronous reset in ACK and in REQ.
        do_reset();
        int_r = 8'h08; step();
        ack_r = 1'b1; step();
        #2; rst_r = 1'b0; #1;
        check("t6_ack_async", {24'd0, int_ack_s}, 32'd0);
        check("t6_int_async", {31'd0, cpu_int_s}, 32'd0);
        check("t6_vect_async", {29'd0, cpu_vect_s}, 32'd0);
        model_reset(); ack_r = 1'b0; int_r = 8'h00;
        @(negedge clk_r); rst_r = 1'b1;
        step(); step();
        int_r = 8'h40; step();
        #2; rst_r = 1'b0; #1;
        check("t6_req_async", {31'd0, cpu_int_s}, 32'd0);
        model_reset(); int_r = 8'h00;
        @(negedge clk_r); rst_r = 1'b1;
        step();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) int_r[b] = ~int_r[b];
            end
            if (int_ack_s != 8'h00 && $urandom_range(0, 3) != 0) int_r = int_r & ~int_ack_s;
            en_r  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
            gie_r = ($urandom_range(0, 15) != 0);
            ack_r = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
